// File: rtl/relu_maxpool2x2_if.sv
// Stream interface between the conv engine and the ReLU/max-pool stage.
// The master side produces conv results; the slave side is the pooling stage.
interface relu_maxpool2x2_if #(
    parameter int DATA_W = 8
);
    logic [2*DATA_W-1:0] din;
    logic                din_valid;
    logic                clear;
    logic [2*DATA_W-1:0] dout;
    logic                dout_valid;
    logic                frame_done;

    modport master (
        output din, din_valid, clear,
        input  dout, dout_valid, frame_done
    );

    modport slave (
        input  din, din_valid, clear,
        output dout, dout_valid, frame_done
    );
endinterface

// File: rtl/relu_maxpool2x2.sv
// Streaming ReLU followed by 2x2 stride-2 max pooling.
// Even rows fold horizontal pairs into a half-row line buffer; odd rows
// fold their own pairs with the buffered maxima and emit one pooled value
// per window. For odd frame heights the final row is counted but ignored.
module relu_maxpool2x2 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input logic              clk,
    input logic              rst_n,
    relu_maxpool2x2_if.slave bus
);
    localparam int W  = 2 * DATA_W;
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LN = IMG_W / 2;
    localparam int LW = (LN > 1) ? $clog2(LN) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_PRE   = RW'(IMG_H - 2);
    localparam bit            ODD_H     = (IMG_H % 2) == 1;

    typedef enum logic [1:0] {
        EVEN_ROW,
        ODD_ROW,
        DRAIN
    } state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [W-1:0]  hold;
    logic [W-1:0]  lbuf [LN];
    logic [W-1:0]  dout_q;
    logic          dout_valid_q;
    logic          frame_done_q;

    logic [W-1:0]  relu;
    logic [W-1:0]  pair_max;
    logic [W-1:0]  pool_max;
    logic [W-1:0]  lbuf_rd;
    logic [LW-1:0] lbuf_idx;
    logic          accept;
    logic          col_wrap;
    logic          row_wrap;
    logic          lbuf_we;

    function automatic logic [W-1:0] umax(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Rectify the input, find the pair/window maxima and decode wrap points.
    always_comb begin
        relu     = bus.din[W-1] ? '0 : bus.din;
        accept   = bus.din_valid && !bus.clear;
        col_wrap = (col == COL_LAST);
        row_wrap = (row == ROW_LAST);
        lbuf_idx = LW'(col >> 1);
        lbuf_rd  = lbuf[lbuf_idx];
        pair_max = umax(hold, relu);
        pool_max = umax(pair_max, lbuf_rd);
        lbuf_we  = accept && (state == EVEN_ROW) && col[0];
    end

    // Line buffer holds no reset: every entry is rewritten on an even row before it is read.
    always_ff @(posedge clk) begin
        if (lbuf_we) begin
            lbuf[lbuf_idx] <= pair_max;
        end
    end

    // Counters, row-parity FSM, hold register and registered output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EVEN_ROW;
            col          <= '0;
            row          <= '0;
            hold         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            dout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.clear) begin
                state <= EVEN_ROW;
                col   <= '0;
                row   <= '0;
            end else if (accept) begin
                col <= col_wrap ? '0 : col + 1'b1;
                if (col_wrap) begin
                    row <= row_wrap ? '0 : row + 1'b1;
                end
                case (state)
                    EVEN_ROW: begin
                        if (!col[0]) begin
                            hold <= relu;
                        end
                        if (col_wrap) begin
                            state <= ODD_ROW;
                        end
                    end
                    ODD_ROW: begin
                        if (!col[0]) begin
                            hold <= relu;
                        end else begin
                            dout_q       <= pool_max;
                            dout_valid_q <= 1'b1;
                            frame_done_q <= col_wrap && row_wrap;
                        end
                        if (col_wrap) begin
                            state <= (ODD_H && (row == ROW_PRE)) ? DRAIN : EVEN_ROW;
                        end
                    end
                    DRAIN: begin
                        if (col_wrap) begin
                            state        <= EVEN_ROW;
                            frame_done_q <= 1'b1;
                        end
                    end
                    default: begin
                        state <= EVEN_ROW;
                    end
                endcase
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Bench for relu_maxpool2x2: a 4x4 instance and a 4x3 instance driven from
// vector tables, with expected pooled outputs queued per instance and
// matched against the strobes on the cycle they are due.
module tb_relu_maxpool2x2;

    typedef struct packed {
        logic [15:0] din;
        logic        fire;
        logic        exp_valid;
        logic [15:0] exp_dout;
        logic        exp_fd;
    } vec_t;

    typedef struct packed {
        int          due;
        logic        valid;
        logic [15:0] dout;
        logic        fd;
    } exp_t;

    logic clk;
    logic rst_n;
    int   pos_count;
    int   checks;
    int   passes;
    exp_t q4[$];
    exp_t q3[$];

    vec_t ramp_vec [16];
    vec_t relu_vec [16];
    vec_t odd_vec  [12];

    relu_maxpool2x2_if #(.DATA_W(8)) if4 ();
    relu_maxpool2x2_if #(.DATA_W(8)) if3 ();

    relu_maxpool2x2 #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.slave)
    );

    relu_maxpool2x2 #(.DATA_W(8), .IMG_W(4), .IMG_H(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3.slave)
    );

    // Free-running clock and an edge counter used to time-stamp expectations.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial pos_count = 0;
    always @(posedge clk) pos_count = pos_count + 1;

    task automatic check_output(input string tag, input logic dv, input logic [15:0] d,
                                input logic fd, input bit expected, input exp_t e);
        checks++;
        if (!expected) begin
            $display("[TB] FAIL %s unexpected strobe: dout_valid=%0b frame_done=%0b dout=%h, required none",
                     tag, dv, fd, d);
        end else if (dv !== e.valid || fd !== e.fd || (e.valid && d !== e.dout)) begin
            $display("[TB] FAIL %s: got dout_valid=%0b dout=%h frame_done=%0b, required dout_valid=%0b dout=%h frame_done=%0b",
                     tag, dv, d, fd, e.valid, e.dout, e.fd);
        end else begin
            passes++;
        end
    endtask

    // Match strobes from the 4x4 instance against its expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (q4.size() > 0 && q4[0].due == pos_count) begin
                check_output("pool_h4", if4.dout_valid, if4.dout, if4.frame_done, 1'b1, q4.pop_front());
            end else if (if4.dout_valid || if4.frame_done) begin
                check_output("pool_h4", if4.dout_valid, if4.dout, if4.frame_done, 1'b0, '0);
            end
        end
    end

    // Match strobes from the odd-height instance against its expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (q3.size() > 0 && q3[0].due == pos_count) begin
                check_output("pool_h3", if3.dout_valid, if3.dout, if3.frame_done, 1'b1, q3.pop_front());
            end else if (if3.dout_valid || if3.frame_done) begin
                check_output("pool_h3", if3.dout_valid, if3.dout, if3.frame_done, 1'b0, '0);
            end
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if4.din_valid = 1'b0;
            if4.clear     = 1'b0;
            if4.din       = 16'($urandom);
            if3.din_valid = 1'b0;
            if3.clear     = 1'b0;
            if3.din       = 16'($urandom);
        end
    endtask

    task automatic apply_stimulus(input bit sel3, input vec_t v, input bit clr, input int gap);
        exp_t e;
        @(negedge clk);
        if (sel3) begin
            if3.din = v.din; if3.din_valid = 1'b1; if3.clear = clr;
        end else begin
            if4.din = v.din; if4.din_valid = 1'b1; if4.clear = clr;
        end
        if (v.fire && !clr) begin
            e = '{due: pos_count + 1, valid: v.exp_valid, dout: v.exp_dout, fd: v.exp_fd};
            if (sel3) q3.push_back(e);
            else      q4.push_back(e);
        end
        if (gap > 0) idle(gap);
    endtask

    task automatic ramp_frame(input int gap);
        for (int i = 0; i < 16; i++) apply_stimulus(1'b0, ramp_vec[i], 1'b0, gap);
    endtask

    initial begin
        logic [15:0] fff0;
        checks = 0;
        passes = 0;
        fff0   = 16'hFFF0;

        // Vector tables: ramp 4x4, ReLU 4x4, ramp 4x3.
        for (int i = 0; i < 16; i++) begin
            ramp_vec[i] = '{din: 16'(i), fire: (i == 5 || i == 7 || i == 13 || i == 15),
                            exp_valid: 1'b1, exp_dout: 16'(i), exp_fd: (i == 15)};
            relu_vec[i] = '{din: (i == 5) ? 16'h7FFF : fff0,
                            fire: (i == 5 || i == 7 || i == 13 || i == 15),
                            exp_valid: 1'b1, exp_dout: (i == 5) ? 16'h7FFF : 16'h0000,
                            exp_fd: (i == 15)};
        end
        for (int i = 0; i < 12; i++) begin
            odd_vec[i] = '{din: 16'(i), fire: (i == 5 || i == 7 || i == 11),
                           exp_valid: (i != 11), exp_dout: 16'(i), exp_fd: (i == 11)};
        end

        if4.din = '0; if4.din_valid = 1'b0; if4.clear = 1'b0;
        if3.din = '0; if3.din_valid = 1'b0; if3.clear = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset held with random inputs: all outputs stay zero.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({if4.dout, if4.dout_valid, if4.frame_done, if3.dout, if3.dout_valid, if3.frame_done} !== '0) begin
                $display("[TB] FAIL reset_outputs: got h4 %h/%0b/%0b h3 %h/%0b/%0b, required all zero",
                         if4.dout, if4.dout_valid, if4.frame_done, if3.dout, if3.dout_valid, if3.frame_done);
            end else begin
                passes++;
            end
            if4.din = 16'($urandom); if4.din_valid = 1'($urandom); if4.clear = 1'($urandom);
            if3.din = 16'($urandom); if3.din_valid = 1'($urandom); if3.clear = 1'($urandom);
        end
        @(negedge clk);
        if4.din_valid = 1'b0; if4.clear = 1'b0;
        if3.din_valid = 1'b0; if3.clear = 1'b0;
        rst_n = 1'b1;
        idle(2);

        $display("[TB] two back-to-back ramp frames");
        ramp_frame(0);
        ramp_frame(0);
        idle(3);

        $display("[TB] ReLU frame");
        for (int i = 0; i < 16; i++) apply_stimulus(1'b0, relu_vec[i], 1'b0, 0);
        idle(3);

        $display("[TB] gapped ramp frame");
        ramp_frame(2);
        idle(3);

        $display("[TB] reset pulsed mid-frame");
        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, ramp_vec[i], 1'b0, 0);
        idle(2);
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        ramp_frame(0);
        idle(3);

        $display("[TB] clear alongside the 7th input");
        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, ramp_vec[i], 1'b0, 0);
        apply_stimulus(1'b0, '{din: 16'h0777, fire: 1'b0, exp_valid: 1'b0, exp_dout: 16'h0, exp_fd: 1'b0}, 1'b1, 0);
        ramp_frame(0);
        idle(3);

        $display("[TB] odd height frames");
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 12; i++) apply_stimulus(1'b1, odd_vec[i], 1'b0, 0);
        end
        idle(4);

        checks++;
        if (q4.size() != 0 || q3.size() != 0) begin
            $display("[TB] FAIL pending_outputs: got %0d/%0d expectations left, required 0/0", q4.size(), q3.size());
        end else begin
            passes++;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/relu_maxpool2x2.md
# relu_maxpool2x2

Streaming ReLU plus 2x2/stride-2 max-pooling stage that sits directly downstream of the convolution engine. It consumes the engine's raster-ordered `pixel_out`/`valid` stream, one result per accepted cycle. It emits one pooled, rectified value per 2x2 window, with a frame-done strobe. A half-row line buffer holds partial maxima between row pairs, so the block needs no frame storage.

## Interface
- `DATA_W`, 8: base data width; input/output samples are 2*DATA_W bits, matching the conv output width.
- `IMG_W`, 8: conv output row length in samples; must be even and ≥2.
- `IMG_H`, 8: conv output rows per frame; must be ≥2. If odd, the last row is discarded.
- Reset: one clock; reset is asynchronous and active-low.
- `clk` in, 1: clock, all state on rising edge.
- `rst_n` in, 1: asynchronous active-low reset.
- `clear` in, 1: synchronous frame restart; zeroes counters and discards partial windows.
- `din` in, 2*DATA_W: conv result, interpreted as two's-complement signed.
- `din_valid` in, 1: `din` is accepted this cycle. There is no backpressure.
- `dout` out, 2*DATA_W: pooled value, always ≥0, MSB always 0.
- `dout_valid` out, 1: one-cycle pulse per pooled value.
- `frame_done` out, 1: one-cycle pulse coincident with the final `dout_valid` of a frame.

## Operation
- ReLU is applied per input: r = (din MSB set) ? 0 : din. All comparisons are unsigned on r.
- Counters:
  - `col` runs 0..IMG_W-1 and advances only on `din_valid`.
  - `row` runs 0..IMG_H-1 and advances when `col` wraps.
- FSM states:
  - EVEN_ROW (row[0]=0)
  - ODD_ROW (row[0]=1)
  - DRAIN (odd IMG_H, last row; inputs counted, nothing stored or emitted)
- EVEN_ROW:
  - On even `col`, store r in hold register.
  - On odd `col`, write max(hold, r) to `lbuf[col>>1]`. The buffer has IMG_W/2 entries of 2*DATA_W bits.
- ODD_ROW:
  - On even `col`, store r in hold register.
  - On odd `col`, register max(hold, r, `lbuf[col>>1]`) into `dout` and pulse `dout_valid` next cycle.
- Transitions:
  - Row wrap toggles EVEN_ROW↔ODD_ROW.
  - After row IMG_H-1, go to EVEN_ROW with row=0. For odd IMG_H, go DRAIN→EVEN_ROW.
  - `frame_done` pulses with the last pooled output, or with the last DRAIN input for odd IMG_H (no `dout_valid` then).
- Idle cycles (`din_valid`=0) freeze all state. `dout_valid`/`frame_done` deassert.
- `clear`:
  - Forces row=col=0, EVEN_ROW, and deasserts strobes next cycle.
  - Has priority over a simultaneous `din_valid`; that pixel is dropped.
  - `lbuf` contents are not cleared; they are overwritten before use.
- `dout` holds its last value between pulses.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `frame_done`=0, row=col=0, state EVEN_ROW, hold=0.
- Latency: `dout_valid` rises exactly 1 cycle after the cycle accepting the odd-row, odd-col input.
- Throughput: one input per cycle sustained, back-to-back frames with no bubble.
- Reset mid-frame: all partial windows are lost. The first input after `rst_n` release is (row 0, col 0).
- Output rate: (IMG_W/2)*(IMG_H/2) pulses per frame (floor on IMG_H). Pulses are never adjacent (≥1 gap cycle).

## Test plan
All scenarios use IMG_W=4, IMG_H=4, DATA_W=8 unless stated.
- Reset: hold `rst_n`=0 with random `din`/`din_valid` → `dout`=0, `dout_valid`=0, `frame_done`=0 throughout.
- Ramp frame:
  - Stimulus: `din`=0..15 raster, `din_valid` continuous.
  - Required: `dout` 5, 7, 13, 15, each one cycle after inputs 5, 7, 13, 15.
  - Required: `frame_done` with the value 15; two consecutive frames give identical outputs.
- ReLU:
  - Stimulus: frame with all `din`=16'hFFF0 except pixel (1,1)=16'h7FFF.
  - Required: outputs 16'h7FFF, 0, 0, 0.
- Gapped input: ramp frame with `din_valid` high every 3rd cycle → same 4 values, each 1 cycle after its triggering input.
- Mid-frame disruption:
  - `rst_n` pulsed low after 6 inputs, then a full ramp → exactly 4 outputs 5, 7, 13, 15.
  - Repeat with `clear` asserted alongside the 7th `din_valid`; the pixel is dropped and the result is the same.
- Odd height:
  - Stimulus: IMG_H=3, ramp 0..11.
  - Required: one output row, 5 then 7; `frame_done` on input 11 with no `dout_valid`.
